// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
// Shared types and constants for the three-master bus arbiter.
//   state_t         : FSM state encoding (IDLE = 0, XFER = 1)
//   grant_t         : granted-master encoding (M0 = 0, M1 = 1, M2 = 2)
//   TIMEOUT_DEFAULT : default slave-ack timeout in cycles
//   timeout_last()  : wait-counter value at which a transfer times out
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        GNT_M0 = 2'd0,
        GNT_M1 = 2'd1,
        GNT_M2 = 2'd2
    } grant_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // The counter starts at 0 in the first XFER cycle, so the Nth XFER cycle
    // sees a count of N-1. A timeout of N cycles therefore fires at N-1.
    function automatic logic [7:0] timeout_last(input int unsigned timeout);
        return 8'(timeout - 32'd1);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
// Bundles the three master request channels and the single slave channel
// seen by the arbiter.
//   m0_* : JTAG debug master (read/write)
//   m1_* : core data (EX) master (read/write)
//   m2_* : core instruction-fetch master (read-only)
//   s_*  : shared slave channel
// Modports:
//   master : the arbiter's view (it masters the shared slave channel and
//            answers the requesting masters)
//   slave  : the environment's view (requesting masters plus slave device)
interface bus_arbiter_if;

    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic [31:0] m0_rdata_o;
    logic        m0_ack_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic [31:0] m1_rdata_o;
    logic        m1_ack_o;

    logic        m2_req_i;
    logic [31:0] m2_addr_i;
    logic [31:0] m2_rdata_o;
    logic        m2_ack_o;

    logic        s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [31:0] s_rdata_i;
    logic        s_ack_i;

    modport master (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m0_rdata_o, m0_ack_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m1_rdata_o, m1_ack_o,
        input  m2_req_i, m2_addr_i,
        output m2_rdata_o, m2_ack_o,
        output s_req_o, s_we_o, s_addr_o, s_wdata_o,
        input  s_rdata_i, s_ack_i
    );

    modport slave (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m0_rdata_o, m0_ack_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m1_rdata_o, m1_ack_o,
        output m2_req_i, m2_addr_i,
        input  m2_rdata_o, m2_ack_o,
        input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
        output s_rdata_i, s_ack_i
    );

endinterface

// File: rtl/bus_arbiter_arb_prio.sv
// arb_prio
// Combinational winner selection for the bus arbiter.
// m0 always wins. Between m1 and m2 the default build uses fixed priority
// (m1 > m2); with BUS_ARB_RR_EN defined, a last-served flag alternates them.
// Ports:
//   req     in  3  request vector {m2, m1, m0}
//   last_m1 in  1  (BUS_ARB_RR_EN only) 1 when m1 was the last of m1/m2 served
//   winner  out 2  selected master (grant_t); GNT_M0 when nothing requests
module arb_prio
    import bus_arbiter_pkg::*;
(
    input  logic [2:0] req,
`ifdef BUS_ARB_RR_EN
    input  logic       last_m1,
`endif
    output grant_t     winner
);

    always_comb begin
        winner = GNT_M0;
        if (req[0]) begin
            winner = GNT_M0;
        end else if (req[1] && req[2]) begin
`ifdef BUS_ARB_RR_EN
            if (last_m1) begin
                winner = GNT_M2;
            end else begin
                winner = GNT_M1;
            end
`else
            winner = GNT_M1;
`endif
        end else if (req[1]) begin
            winner = GNT_M1;
        end else if (req[2]) begin
            winner = GNT_M2;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Arbitrates three masters (m0 JTAG, m1 core data, m2 instruction fetch)
// onto one slave channel. A grant is registered in IDLE, the slave is driven
// combinationally from the granted master in XFER, and the transfer ends on
// slave ack or on a wait-cycle timeout.
// Optional feature: define BUS_ARB_RR_EN for round-robin between m1 and m2.
// Ports:
//   clk         in   core clock, rising edge
//   rst         in   asynchronous active-low reset
//   bus         if   bus_arbiter_if.master (all master and slave channels)
//   hold_flag_o out  pipeline hold while m1 or m2 waits for its ack
//   err_o       out  one-cycle pulse on slave timeout
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer; slave outputs 0; next request is arbitrated
// XFER  | granted master drives the slave; waits for ack or timeout
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus,
    output logic          hold_flag_o,
    output logic          err_o
);

    localparam logic [7:0] TO_LAST = timeout_last(TIMEOUT);

    state_t     state;
    grant_t     grant;
    grant_t     winner;
    logic [7:0] wait_cnt;
    logic [2:0] req_vec;
    logic       any_req;
    logic       slave_ack;
    logic       timeout_hit;
    logic       xfer_done;
    logic [2:0] ack_vec;

`ifdef BUS_ARB_RR_EN
    logic       last_m1;
`endif

    assign req_vec = {bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
    assign any_req = |req_vec;

    arb_prio u_arb_prio (
        .req     (req_vec),
`ifdef BUS_ARB_RR_EN
        .last_m1 (last_m1),
`endif
        .winner  (winner)
    );

    // A slave ack in the timeout cycle is a normal completion, not an error.
    assign slave_ack   = (state == XFER) && bus.s_ack_i;
    assign timeout_hit = (state == XFER) && !bus.s_ack_i && (wait_cnt == TO_LAST);
    assign xfer_done   = slave_ack || timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= GNT_M0;
            wait_cnt <= '0;
`ifdef BUS_ARB_RR_EN
            last_m1  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= winner;
                        wait_cnt <= '0;
                        state    <= XFER;
`ifdef BUS_ARB_RR_EN
                        if (winner == GNT_M1) begin
                            last_m1 <= 1'b1;
                        end else if (winner == GNT_M2) begin
                            last_m1 <= 1'b0;
                        end
`endif
                    end
                end
                XFER: begin
                    if (xfer_done) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Slave-side mux and master-side ack/rdata. Request signals are not
    // latched: masters hold them stable until their ack.
    always_comb begin
        bus.s_req_o    = 1'b0;
        bus.s_we_o     = 1'b0;
        bus.s_addr_o   = '0;
        bus.s_wdata_o  = '0;
        bus.m0_rdata_o = '0;
        bus.m1_rdata_o = '0;
        bus.m2_rdata_o = '0;
        ack_vec        = 3'b000;
        err_o          = 1'b0;
        if (state == XFER) begin
            bus.s_req_o = 1'b1;
            err_o       = timeout_hit;
            case (grant)
                GNT_M0: begin
                    bus.s_we_o    = bus.m0_we_i;
                    bus.s_addr_o  = bus.m0_addr_i;
                    bus.s_wdata_o = bus.m0_wdata_i;
                    ack_vec[0]    = xfer_done;
                    if (slave_ack) begin
                        bus.m0_rdata_o = bus.s_rdata_i;
                    end
                end
                GNT_M1: begin
                    bus.s_we_o    = bus.m1_we_i;
                    bus.s_addr_o  = bus.m1_addr_i;
                    bus.s_wdata_o = bus.m1_wdata_i;
                    ack_vec[1]    = xfer_done;
                    if (slave_ack) begin
                        bus.m1_rdata_o = bus.s_rdata_i;
                    end
                end
                GNT_M2: begin
                    bus.s_addr_o = bus.m2_addr_i;
                    ack_vec[2]   = xfer_done;
                    if (slave_ack) begin
                        bus.m2_rdata_o = bus.s_rdata_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.m0_ack_o = ack_vec[0];
    assign bus.m1_ack_o = ack_vec[1];
    assign bus.m2_ack_o = ack_vec[2];

    // Gated by rst so the flag is 0 while reset is held even though the
    // request inputs may be active.
    assign hold_flag_o = rst && ((bus.m1_req_i && !ack_vec[1]) ||
                                 (bus.m2_req_i && !ack_vec[2]));

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hold_flag;
    logic err;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .hold_flag_o (hold_flag),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.m0_req_i   = 1'b0;
        bus.m0_we_i    = 1'b0;
        bus.m0_addr_i  = '0;
        bus.m0_wdata_i = '0;
        bus.m1_req_i   = 1'b0;
        bus.m1_we_i    = 1'b0;
        bus.m1_addr_i  = '0;
        bus.m1_wdata_i = '0;
        bus.m2_req_i   = 1'b0;
        bus.m2_addr_i  = '0;
        bus.s_rdata_i  = '0;
        bus.s_ack_i    = 1'b0;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        bus.m1_req_i  = 1'b1;
        bus.m2_req_i  = 1'b1;
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        n_checks++; if (hold_flag !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0", hold_flag); end
        n_checks++; if (bus.s_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_req: got %b expected 0", bus.s_req_o); end
        n_checks++; if ({bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o}); end
        n_checks++; if ({bus.s_we_o, bus.s_addr_o, bus.s_wdata_o} !== 65'd0) begin n_fail++; $display("FAIL reset_s_bus: got %h expected 0", {bus.s_we_o, bus.s_addr_o, bus.s_wdata_o}); end
        n_checks++; if ({bus.m0_rdata_o, bus.m1_rdata_o, bus.m2_rdata_o, err} !== 97'd0) begin n_fail++; $display("FAIL reset_rdata_err: got %h expected 0", {bus.m0_rdata_o, bus.m1_rdata_o, bus.m2_rdata_o, err}); end
        clear_inputs();
        rst = 1'b1;
        to_drive();
    endtask

    task automatic test_m1_write();
        bus.m1_req_i   = 1'b1;
        bus.m1_we_i    = 1'b1;
        bus.m1_addr_i  = 32'h1000_0004;
        bus.m1_wdata_i = 32'hA5A5_5A5A;
        to_sample();
        n_checks++; if (bus.s_req_o !== 1'b0) begin n_fail++; $display("FAIL wr_idle_s_req: got %b expected 0", bus.s_req_o); end
        n_checks++; if (hold_flag !== 1'b1) begin n_fail++; $display("FAIL wr_idle_hold: got %b expected 1", hold_flag); end
        to_drive();
        to_sample();
        n_checks++; if (bus.s_req_o !== 1'b1) begin n_fail++; $display("FAIL wr_xfer_s_req: got %b expected 1", bus.s_req_o); end
        n_checks++; if ({bus.s_we_o, bus.s_addr_o, bus.s_wdata_o} !== {1'b1, 32'h1000_0004, 32'hA5A5_5A5A}) begin n_fail++; $display("FAIL wr_xfer_bus: got %h expected %h", {bus.s_we_o, bus.s_addr_o, bus.s_wdata_o}, {1'b1, 32'h1000_0004, 32'hA5A5_5A5A}); end
        n_checks++; if (bus.m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack: got %b expected 0", bus.m1_ack_o); end
        n_checks++; if (hold_flag !== 1'b1) begin n_fail++; $display("FAIL wr_xfer_hold: got %b expected 1", hold_flag); end
        to_drive();
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'h0BAD_F00D;
        to_sample();
        n_checks++; if ({bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o} !== 3'b010) begin n_fail++; $display("FAIL wr_ack: got %b expected 010", {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o}); end
        n_checks++; if (hold_flag !== 1'b0) begin n_fail++; $display("FAIL wr_ack_hold: got %b expected 0", hold_flag); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_ack_err: got %b expected 0", err); end
        to_drive();
        clear_inputs();
        to_sample();
        n_checks++; if ({bus.s_req_o, bus.m1_ack_o, hold_flag} !== 3'b000) begin n_fail++; $display("FAIL wr_after: got %b expected 000", {bus.s_req_o, bus.m1_ack_o, hold_flag}); end
        to_drive();
    endtask

    task automatic test_m2_read();
        bus.m2_req_i  = 1'b1;
        bus.m2_addr_i = 32'h0000_0100;
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'h0000_0013;
        to_sample();
        n_checks++; if ({bus.m2_ack_o, bus.m2_rdata_o} !== 33'd0) begin n_fail++; $display("FAIL rd_idle_ack_ignored: got %h expected 0", {bus.m2_ack_o, bus.m2_rdata_o}); end
        to_drive();
        bus.s_ack_i = 1'b0;
        to_sample();
        n_checks++; if ({bus.s_req_o, bus.s_we_o, bus.s_addr_o} !== {1'b1, 1'b0, 32'h0000_0100}) begin n_fail++; $display("FAIL rd_xfer_bus: got %h expected %h", {bus.s_req_o, bus.s_we_o, bus.s_addr_o}, {1'b1, 1'b0, 32'h0000_0100}); end
        n_checks++; if ({bus.m2_ack_o, bus.m2_rdata_o} !== 33'd0) begin n_fail++; $display("FAIL rd_wait: got %h expected 0", {bus.m2_ack_o, bus.m2_rdata_o}); end
        to_drive();
        bus.s_ack_i = 1'b1;
        to_sample();
        n_checks++; if ({bus.m2_ack_o, bus.m2_rdata_o} !== {1'b1, 32'h0000_0013}) begin n_fail++; $display("FAIL rd_ack_data: got %h expected %h", {bus.m2_ack_o, bus.m2_rdata_o}, {1'b1, 32'h0000_0013}); end
        n_checks++; if ({bus.s_we_o, hold_flag} !== 2'b00) begin n_fail++; $display("FAIL rd_ack_we_hold: got %b expected 00", {bus.s_we_o, hold_flag}); end
        to_drive();
        clear_inputs();
        to_sample();
        n_checks++; if ({bus.s_req_o, bus.m2_rdata_o} !== 33'd0) begin n_fail++; $display("FAIL rd_after: got %h expected 0", {bus.s_req_o, bus.m2_rdata_o}); end
        to_drive();
    endtask

    task automatic test_fixed_priority();
        logic [2:0]  exp_ack  [6] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
        logic [31:0] exp_addr [6] = '{32'h0, 32'hA000_0000, 32'h0, 32'hA000_0001, 32'h0, 32'hA000_0002};
        logic        exp_hold [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] rd;
        rd = 32'hCAFE_0001;
        bus.m0_req_i  = 1'b1;
        bus.m0_addr_i = 32'hA000_0000;
        bus.m1_req_i  = 1'b1;
        bus.m1_addr_i = 32'hA000_0001;
        bus.m2_req_i  = 1'b1;
        bus.m2_addr_i = 32'hA000_0002;
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = rd;
        for (int c = 0; c < 6; c++) begin
            to_sample();
            n_checks++; if ({bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o} !== exp_ack[c]) begin n_fail++; $display("FAIL prio_acks c%0d: got %b expected %b", c, {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o}, exp_ack[c]); end
            n_checks++; if ({bus.s_req_o, bus.s_addr_o} !== {(c % 2 == 1), exp_addr[c]}) begin n_fail++; $display("FAIL prio_s_bus c%0d: got %h expected %h", c, {bus.s_req_o, bus.s_addr_o}, {(c % 2 == 1), exp_addr[c]}); end
            n_checks++; if ({bus.m0_rdata_o, bus.m1_rdata_o, bus.m2_rdata_o} !== {(exp_ack[c][0] ? rd : 32'h0), (exp_ack[c][1] ? rd : 32'h0), (exp_ack[c][2] ? rd : 32'h0)}) begin n_fail++; $display("FAIL prio_rdata c%0d: got %h", c, {bus.m0_rdata_o, bus.m1_rdata_o, bus.m2_rdata_o}); end
            n_checks++; if (hold_flag !== exp_hold[c]) begin n_fail++; $display("FAIL prio_hold c%0d: got %b expected %b", c, hold_flag, exp_hold[c]); end
            to_drive();
            if (exp_ack[c][0]) bus.m0_req_i = 1'b0;
            if (exp_ack[c][1]) bus.m1_req_i = 1'b0;
            if (exp_ack[c][2]) bus.m2_req_i = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_m1_m2_contention();
`ifdef BUS_ARB_RR_EN
        logic [2:0] exp_ack [6] = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b010};
`else
        logic [2:0] exp_ack [6] = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010};
`endif
        bus.m1_req_i  = 1'b1;
        bus.m1_addr_i = 32'hB000_0001;
        bus.m2_req_i  = 1'b1;
        bus.m2_addr_i = 32'hB000_0002;
        bus.s_ack_i   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            to_sample();
            n_checks++; if ({bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o} !== exp_ack[c]) begin n_fail++; $display("FAIL m1m2_acks c%0d: got %b expected %b", c, {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o}, exp_ack[c]); end
            n_checks++; if (hold_flag !== 1'b1) begin n_fail++; $display("FAIL m1m2_hold c%0d: got %b expected 1", c, hold_flag); end
            to_drive();
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic exp_sreq [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_to   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.m0_req_i   = 1'b1;
        bus.m0_we_i    = 1'b1;
        bus.m0_addr_i  = 32'h0000_2000;
        bus.m0_wdata_i = 32'h0000_0042;
        bus.s_rdata_i  = 32'h5555_AAAA;
        for (int c = 0; c < 6; c++) begin
            to_sample();
            n_checks++; if (bus.s_req_o !== exp_sreq[c]) begin n_fail++; $display("FAIL to_s_req c%0d: got %b expected %b", c, bus.s_req_o, exp_sreq[c]); end
            n_checks++; if ({bus.m0_ack_o, err} !== {exp_to[c], exp_to[c]}) begin n_fail++; $display("FAIL to_ack_err c%0d: got %b expected %b", c, {bus.m0_ack_o, err}, {exp_to[c], exp_to[c]}); end
            n_checks++; if ({bus.m0_rdata_o, hold_flag} !== 33'd0) begin n_fail++; $display("FAIL to_rdata_hold c%0d: got %h expected 0", c, {bus.m0_rdata_o, hold_flag}); end
            to_drive();
            if (exp_to[c]) bus.m0_req_i = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_ack_at_timeout();
        bus.m1_req_i  = 1'b1;
        bus.m1_addr_i = 32'h0000_3004;
        to_sample();
        for (int c = 1; c < 4; c++) begin
            to_drive();
            to_sample();
            n_checks++; if ({bus.s_req_o, bus.m1_ack_o, err} !== 3'b100) begin n_fail++; $display("FAIL tie_wait c%0d: got %b expected 100", c, {bus.s_req_o, bus.m1_ack_o, err}); end
        end
        to_drive();
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'h1234_5678;
        to_sample();
        n_checks++; if ({bus.m1_ack_o, err} !== 2'b10) begin n_fail++; $display("FAIL tie_ack_err: got %b expected 10", {bus.m1_ack_o, err}); end
        n_checks++; if (bus.m1_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL tie_rdata: got %h expected 12345678", bus.m1_rdata_o); end
        to_drive();
        clear_inputs();
        to_sample();
        n_checks++; if ({bus.s_req_o, bus.m1_ack_o, err} !== 3'b000) begin n_fail++; $display("FAIL tie_after: got %b expected 000", {bus.s_req_o, bus.m1_ack_o, err}); end
        to_drive();
    endtask

    task automatic test_reset_mid_xfer();
        bus.m1_req_i   = 1'b1;
        bus.m1_we_i    = 1'b1;
        bus.m1_addr_i  = 32'h0000_3000;
        bus.m1_wdata_i = 32'h0000_0077;
        to_sample();
        to_drive();
        to_sample();
        n_checks++; if (bus.s_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_s_req: got %b expected 1", bus.s_req_o); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'hEEEE_EEEE;
        #1;
        n_checks++; if ({bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o} !== 66'd0) begin n_fail++; $display("FAIL rst_async_s_bus: got %h expected 0", {bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o}); end
        n_checks++; if ({bus.m1_ack_o, bus.m1_rdata_o, hold_flag, err} !== 35'd0) begin n_fail++; $display("FAIL rst_async_ack: got %h expected 0", {bus.m1_ack_o, bus.m1_rdata_o, hold_flag, err}); end
        @(negedge clk);
        bus.s_ack_i = 1'b0;
        rst = 1'b1;
        to_drive();
        to_sample();
        n_checks++; if ({bus.s_req_o, bus.s_we_o, bus.s_addr_o} !== {1'b1, 1'b1, 32'h0000_3000}) begin n_fail++; $display("FAIL rst_regrant: got %h expected %h", {bus.s_req_o, bus.s_we_o, bus.s_addr_o}, {1'b1, 1'b1, 32'h0000_3000}); end
        to_drive();
        bus.s_ack_i = 1'b1;
        to_sample();
        n_checks++; if (bus.m1_ack_o !== 1'b1) begin n_fail++; $display("FAIL rst_reack: got %b expected 1", bus.m1_ack_o); end
        to_drive();
        clear_inputs();
        to_sample();
        n_checks++; if (bus.s_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_after: got %b expected 0", bus.s_req_o); end
        to_drive();
    endtask

    initial begin
        test_reset();
        test_m1_write();
        test_m2_read();
        test_fixed_priority();
        test_m1_m2_contention();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_xfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
